mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Word-addressed main-memory responder at the far end of the datapath's MAR/MDR memory port.
- Accepts one read or write request at a time, using the address from MAR and the write data from MDR.
- Returns read data to the MDR's Mdatain input and signals completion with a one-cycle mem_done pulse (memory-function-complete).
- Wait states are configurable, so control-unit stall logic can be exercised.

Parameters:
- ADDR_W, 9, address width; matches the datapath's address bus.
- DATA_W, 32, word width.
- DEPTH, 512, number of implemented words; must be ≤ 2^ADDR_W.
- WAIT_CYCLES, 2, extra cycles spent in BUSY before completion; legal range 0..15.
- PROTECT_LIMIT, 64, first writable word address; used only with MEM_PROTECT_EN.

Ports:
- clock  in  1  system clock; all logic on posedge.
- clear  in  1  synchronous reset, active-low (clear=0 resets on the next posedge).
- address  in  ADDR_W  word address from MAR.
- wr_data  in  DATA_W  write data from MDR.
- mem_read  in  1  read request level.
- mem_write  in  1  write request level.
- rd_data  out  DATA_W  read data to MDR Mdatain.
- mem_done  out  1  one-cycle completion pulse.
- mem_busy  out  1  high from request accept until the request is dropped.
- mem_err  out  1  one-cycle pulse on an illegal or rejected request.

Behaviour:
- Reset (clear=0 at posedge):
  - FSM goes to IDLE; rd_data=0, mem_done=0, mem_busy=0, mem_err=0, wait counter=0.
  - Array contents are NOT cleared.
  - Reset mid-transaction aborts it: no done pulse, and a pending write is not committed.
- FSM states: IDLE, BUSY, DONE, HOLD.
- IDLE:
  - Exactly one of mem_read/mem_write high: latch address and wr_data plus op type, load counter=WAIT_CYCLES, go to BUSY, mem_busy=1.
  - Both high: do not accept; pulse mem_err for one cycle; stay in IDLE. The pulse repeats each cycle while both stay high.
  - Neither high: remain in IDLE.
- BUSY:
  - Counter nonzero: decrement each cycle.
  - Counter zero: perform the operation and go to DONE.
  - Latency: mem_done is asserted WAIT_CYCLES+2 cycles after the accepting edge, i.e. 2 cycles when WAIT_CYCLES=0.
  - Inputs are ignored after the latch, so changing address or wr_data mid-BUSY has no effect.
- Operation:
  - Read: rd_data <= mem[latched address].
  - Write: mem[latched address] <= latched wr_data. rd_data is unchanged; it holds the last read value until the next completed read.
- DONE:
  - mem_done=1 for exactly one cycle, then go to HOLD.
- HOLD:
  - Wait until mem_read and mem_write are both low, then go to IDLE and set mem_busy=0.
  - This prevents a held request level from retriggering.
  - A dropped request followed by a re-raise in the next cycle is accepted normally from IDLE.
- Requester drops the request during BUSY:
  - The operation still completes and pulses done, because it was latched.
- Out-of-range address (≥ DEPTH):
  - Read returns 0 and write is discarded.
  - mem_err pulses in the same cycle as mem_done, and done still occurs.
- The array is inferred synchronous single-port RAM with one access per cycle, only in the perform cycle.

Optional Feature:
- Macro MEM_PROTECT_EN.
- Defined: writes to addresses < PROTECT_LIMIT are discarded. mem_err pulses together with mem_done, and done is still given so the control unit never deadlocks. Reads are unaffected.
- Undefined: all in-range addresses are writable, PROTECT_LIMIT is unused, and no protect logic is synthesized.

Decomposition:
- Shared package mem_pkg:
  - FSM state encoding typedef: IDLE=2'd0, BUSY=2'd1, DONE=2'd2, HOLD=2'd3.
  - Op-type enum: OP_RD, OP_WR.
  - Default ADDR_W/DATA_W constants shared with the MAR/MDR blocks.
- One natural sub-module, mem_array: a DEPTH×DATA_W synchronous RAM with we, addr, din and dout. It isolates inference and is swappable for a vendor macro.
- The FSM, counter and request latch stay in mem_responder.

Test Plan:
- Write then read, WAIT_CYCLES=2:
  - mem_write=1, address=9'h05C, wr_data=32'hDEADBEEF → mem_done 4 cycles after accept; drop request.
  - mem_read at 9'h05C → rd_data=32'hDEADBEEF when mem_done pulses.
- Held request: mem_read held high 10 cycles → exactly one mem_done pulse; mem_busy stays 1 until mem_read falls.
- Both high: mem_read=mem_write=1 for 3 cycles → mem_err high for 3 cycles, no mem_done, memory unchanged.
- Reset mid-operation:
  - Write 32'h12345678 to 9'h010; clear=0 during BUSY → no mem_done, all outputs 0.
  - Subsequent read of 9'h010 returns the prior contents.
- Out of range: DEPTH=256, read at 9'h1F0 → rd_data=0, mem_err and mem_done pulse in the same cycle.
- MEM_PROTECT_EN with PROTECT_LIMIT=64:
  - Write 32'hAAAA5555 to 9'h020 → mem_err together with mem_done; read back yields the old value.
  - Write to 9'h040 succeeds with no mem_err.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared types and default widths for the MAR/MDR memory port.
package mem_pkg;

  localparam int MEM_ADDR_W = 9;
  localparam int MEM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2,
    HOLD = 2'd3
  } mem_state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage

// File: rtl/mem_array.sv
// mem_array: DEPTH x DATA_W synchronous single-port RAM. Kept separate so a
// vendor macro can be dropped in without touching the responder FSM.
module mem_array #(
  parameter int DEPTH  = 512,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
) (
  input  logic              clock,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [DEPTH];

  // One access per enabled cycle: write, or registered read.
  always_ff @(posedge clock) begin
    if (en) begin
      if (we) begin
        mem[addr] <= din;
      end
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: word-addressed main-memory responder behind MAR/MDR.
// One request at a time, WAIT_CYCLES extra busy cycles, one-cycle mem_done.
// Build macro MEM_PROTECT_EN: discard writes below PROTECT_LIMIT and flag
// them on mem_err; without it the PROTECT_LIMIT parameter does not exist.
//
// state | meaning
// IDLE  | waiting for exactly one of mem_read/mem_write
// BUSY  | request latched, counting down wait states, then access RAM
// DONE  | capture read data, pulse mem_done (and mem_err if rejected)
// HOLD  | wait for both request levels low so a held level cannot retrigger
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = MEM_ADDR_W,
  parameter int DATA_W      = MEM_DATA_W,
  parameter int DEPTH       = 512,
  parameter int WAIT_CYCLES = 2
`ifdef MEM_PROTECT_EN
  ,
  parameter int PROTECT_LIMIT = 64
`endif
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_done,
  output logic              mem_busy,
  output logic              mem_err
);

  localparam int         RAM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  mem_state_t        state;
  op_t               lat_op;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic [3:0]        wait_cnt;

  logic              in_range;
  logic              wr_blocked;
  logic              perform;
  logic              ram_en;
  logic              ram_we;
  logic [DATA_W-1:0] ram_dout;

  assign in_range = (32'(lat_addr) < 32'(DEPTH));

`ifdef MEM_PROTECT_EN
  assign wr_blocked = (lat_op == OP_WR) && (32'(lat_addr) < 32'(PROTECT_LIMIT));
`else
  assign wr_blocked = 1'b0;
`endif

  // The RAM is touched only in the last BUSY cycle; a reset on that same
  // edge must not let a pending write land.
  assign perform = (state == BUSY) && (wait_cnt == 4'd0);
  assign ram_en  = perform && in_range && clear;
  assign ram_we  = ram_en && (lat_op == OP_WR) && !wr_blocked;

  mem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (RAM_AW)
  ) u_array (
    .clock (clock),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (lat_addr[RAM_AW-1:0]),
    .din   (lat_data),
    .dout  (ram_dout)
  );

  // Request FSM with wait counter, request latch and registered outputs.
  always_ff @(posedge clock) begin
    if (!clear) begin
      state    <= IDLE;
      lat_op   <= OP_RD;
      lat_addr <= '0;
      lat_data <= '0;
      wait_cnt <= 4'd0;
      rd_data  <= '0;
      mem_done <= 1'b0;
      mem_busy <= 1'b0;
      mem_err  <= 1'b0;
    end else begin
      mem_done <= 1'b0;
      mem_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_read ^ mem_write) begin
            lat_op   <= mem_write ? OP_WR : OP_RD;
            lat_addr <= address;
            lat_data <= wr_data;
            wait_cnt <= WAIT_LD;
            mem_busy <= 1'b1;
            state    <= BUSY;
          end else if (mem_read && mem_write) begin
            mem_err <= 1'b1;
          end
        end
        BUSY: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            state <= DONE;
          end
        end
        DONE: begin
          mem_done <= 1'b1;
          mem_err  <= !in_range || wr_blocked;
          if (lat_op == OP_RD) begin
            rd_data <= in_range ? ram_dout : '0;
          end
          state <= HOLD;
        end
        HOLD: begin
          if (!mem_read && !mem_write) begin
            mem_busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed stimulus against a timestamp-based model of the
// responder (memory contents in an associative array, completion scheduled at
// accept + WAIT_CYCLES + 2), compared every cycle, plus literal spot checks.
module tb_mem_responder;

  localparam int AW    = 9;
  localparam int DW    = 32;
  localparam int DEPTH = 256;
  localparam int WAITC = 2;
  localparam int PLIM  = 64;
`ifdef MEM_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          clear = 1'b0;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] wr_data = '0;
  logic          mem_read = 1'b0;
  logic          mem_write = 1'b0;
  logic [DW-1:0] rd_data;
  logic          mem_done;
  logic          mem_busy;
  logic          mem_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clock = ~clock;

  mem_responder #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (WAITC)
  ) dut (
    .clock     (clock),
    .clear     (clear),
    .address   (address),
    .wr_data   (wr_data),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .rd_data   (rd_data),
    .mem_done  (mem_done),
    .mem_busy  (mem_busy),
    .mem_err   (mem_err)
  );

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model state: what the outputs must be after each posedge.
  logic [DW-1:0] mem_m [int];
  bit            e_done = 1'b0;
  bit            e_err  = 1'b0;
  bit            e_busy = 1'b0;
  bit            e_rd_known = 1'b1;
  logic [DW-1:0] e_rd = '0;
  bit            pend = 1'b0;
  bit            holding = 1'b0;
  int            done_at = 0;
  bit            m_wr = 1'b0;
  int            m_addr = 0;
  logic [DW-1:0] m_data = '0;

  always @(posedge clock) begin
    cyc++;
    e_done = 1'b0;
    e_err  = 1'b0;
    if (!clear) begin
      pend = 1'b0; holding = 1'b0; e_busy = 1'b0; e_rd = '0; e_rd_known = 1'b1;
    end else if (pend) begin
      if (cyc == done_at) begin
        e_done = 1'b1; pend = 1'b0; holding = 1'b1;
        if (m_addr >= DEPTH) begin
          e_err = 1'b1;
          if (!m_wr) begin e_rd = '0; e_rd_known = 1'b1; end
        end else if (m_wr) begin
          if (PROT && m_addr < PLIM) e_err = 1'b1;
          else mem_m[m_addr] = m_data;
        end else if (mem_m.exists(m_addr)) begin
          e_rd = mem_m[m_addr]; e_rd_known = 1'b1;
        end else begin
          e_rd_known = 1'b0;
        end
      end
    end else if (holding) begin
      if (!mem_read && !mem_write) begin holding = 1'b0; e_busy = 1'b0; end
    end else if (mem_read && mem_write) begin
      e_err = 1'b1;
    end else if (mem_read || mem_write) begin
      pend = 1'b1; e_busy = 1'b1; m_wr = mem_write;
      m_addr = int'(address); m_data = wr_data; done_at = cyc + WAITC + 2;
    end
  end

  // Compare process: every cycle once out of reset.
  bit chk_en    = 1'b0;
  int dn_cnt    = 0;
  int er_cnt    = 0;
  int last_done = -1;
  int last_err  = -2;

  always @(negedge clock) begin
    if (chk_en) begin
      chk("mem_done", {31'd0, mem_done}, {31'd0, e_done});
      chk("mem_err", {31'd0, mem_err}, {31'd0, e_err});
      chk("mem_busy", {31'd0, mem_busy}, {31'd0, e_busy});
      if (e_rd_known) chk("rd_data", rd_data, e_rd);
      if (mem_done === 1'b1) begin dn_cnt++; last_done = cyc; end
      if (mem_err === 1'b1) begin er_cnt++; last_err = cyc; end
    end
  end

  // Tasks are entered and left 1 time unit after a negedge.
  task automatic req(input bit rd, input bit wr, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input int hold, input bit scramble,
                     output int acc);
    address = a; wr_data = d; mem_read = rd; mem_write = wr;
    acc = cyc + 1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock); #1;
      if (scramble && i == 0) begin address = ~a; wr_data = ~d; end
    end
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  int acc, d0, e0;

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_en = 1'b1;
    chk("reset rd_data", rd_data, 32'h0);
    chk("reset busy", {31'd0, mem_busy}, 32'd0);
    #1 clear = 1'b1;
    idle(2);

    // write then read back, latency WAITC+2
    req(1'b0, 1'b1, 9'h05C, 32'hDEADBEEF, 5, 1'b0, acc);
    idle(3);
    chk("write latency", 32'(last_done - acc), 32'd4);
    req(1'b1, 1'b0, 9'h05C, 32'h0, 6, 1'b0, acc);
    idle(3);
    chk("read latency", 32'(last_done - acc), 32'd4);
    chk("read 05C", rd_data, 32'hDEADBEEF);

    req(1'b0, 1'b1, 9'h010, 32'hCAFEF00D, 6, 1'b0, acc);
    idle(2);

    // held read level: single completion, busy until drop
    d0 = dn_cnt;
    req(1'b1, 1'b0, 9'h05C, 32'h0, 10, 1'b0, acc);
    chk("held busy", {31'd0, mem_busy}, 32'd1);
    idle(3);
    chk("held done count", 32'(dn_cnt - d0), 32'd1);
    chk("held busy released", {31'd0, mem_busy}, 32'd0);

    // both requests high for 3 cycles
    d0 = dn_cnt; e0 = er_cnt;
    req(1'b1, 1'b1, 9'h05C, 32'h11111111, 3, 1'b0, acc);
    idle(3);
    chk("both err count", 32'(er_cnt - e0), 32'd3);
    chk("both done count", 32'(dn_cnt - d0), 32'd0);

    // reset in the middle of a write
    d0 = dn_cnt;
    address = 9'h010; wr_data = 32'h12345678; mem_write = 1'b1;
    idle(2);
    clear = 1'b0; mem_write = 1'b0;
    @(negedge clock);
    chk("abort rd_data", rd_data, 32'h0);
    chk("abort busy", {31'd0, mem_busy}, 32'd0);
    chk("abort done", {31'd0, mem_done}, 32'd0);
    chk("abort err", {31'd0, mem_err}, 32'd0);
    #1 clear = 1'b1;
    idle(6);
    chk("abort no done", 32'(dn_cnt - d0), 32'd0);
    req(1'b1, 1'b0, 9'h010, 32'h0, 6, 1'b0, acc);
    idle(2);
`ifndef MEM_PROTECT_EN
    chk("read after abort", rd_data, 32'hCAFEF00D);
`endif

    // out-of-range read
    e0 = er_cnt;
    req(1'b1, 1'b0, 9'h1F0, 32'h0, 6, 1'b0, acc);
    idle(2);
    chk("oor rd_data", rd_data, 32'h0);
    chk("oor err count", 32'(er_cnt - e0), 32'd1);
    chk("oor err with done", 32'(last_err), 32'(last_done));

    // write below the protect limit
    d0 = dn_cnt; e0 = er_cnt;
    req(1'b0, 1'b1, 9'h020, 32'hAAAA5555, 6, 1'b0, acc);
    idle(2);
    chk("low write done", 32'(dn_cnt - d0), 32'd1);
`ifdef MEM_PROTECT_EN
    chk("low write err", 32'(er_cnt - e0), 32'd1);
    chk("low write err with done", 32'(last_err), 32'(last_done));
`else
    chk("low write err", 32'(er_cnt - e0), 32'd0);
    req(1'b1, 1'b0, 9'h020, 32'h0, 6, 1'b0, acc);
    idle(2);
    chk("low write readback", rd_data, 32'hAAAA5555);
`endif

    // write at the limit
    e0 = er_cnt;
    req(1'b0, 1'b1, 9'h040, 32'h12121212, 6, 1'b0, acc);
    idle(2);
    chk("limit write err", 32'(er_cnt - e0), 32'd0);
    req(1'b1, 1'b0, 9'h040, 32'h0, 6, 1'b0, acc);
    idle(2);
    chk("limit readback", rd_data, 32'h12121212);

    // drop during BUSY with inputs changed after the latch
    d0 = dn_cnt;
    req(1'b0, 1'b1, 9'h077, 32'h0BADC0DE, 2, 1'b1, acc);
    idle(6);
    chk("dropped done count", 32'(dn_cnt - d0), 32'd1);
    req(1'b1, 1'b0, 9'h077, 32'h0, 5, 1'b0, acc);
    idle(1);
    req(1'b1, 1'b0, 9'h05C, 32'h0, 5, 1'b0, acc);
    chk("reraise latency", 32'(last_done - acc), 32'd4);
    chk("reraise data", rd_data, 32'hDEADBEEF);
    idle(3);
    req(1'b1, 1'b0, 9'h077, 32'h0, 6, 1'b0, acc);
    idle(2);
    chk("latched write data", rd_data, 32'h0BADC0DE);

    idle(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
